mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single-port synchronous memory (1 K × 32-bit words) between the core's instruction-fetch port and its load/store data port. This allows one unified RAM to back both address_IMEM and address_DMEM traffic. The block sits between CPU_Core and the RAM macro. It grants at most one access per cycle, favours data accesses, and bounds fetch starvation with a counter. Read data is steered back to the requester that issued the read.

## Interface
- ADDR_W, 10, word address width (matches the core's 10-bit memory addresses)
- DATA_W, 32, data width
- STARVE_MAX, 3, consecutive fetch denials allowed before fetch is forced to win (1..15)
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held until if_gnt
- if_addr  input  ADDR_W  fetch word address; stable while if_req=1 and if_gnt=0
- if_gnt  output  1  fetch accepted this cycle (combinational)
- if_rvalid  output  1  if_rdata valid (cycle after grant)
- if_rdata  output  DATA_W  fetched word
- d_req  input  1  data request; held until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data word address
- d_wdata  input  DATA_W  store data
- d_gnt  output  1  data access accepted this cycle (combinational)
- d_rvalid  output  1  d_rdata valid (loads only, cycle after grant)
- d_rdata  output  DATA_W  loaded word
- mem_en  output  1  RAM access enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- Grant decision is combinational from requests and the starvation state. At most one of if_gnt/d_gnt is 1.
  - Only one requester active: that requester is granted.
  - Both active, starve_cnt < STARVE_MAX: d_gnt=1. starve_cnt increments and saturates at STARVE_MAX.
  - Both active, starve_cnt == STARVE_MAX: if_gnt=1.
  - Any cycle with if_gnt=1, or with if_req=0, clears starve_cnt to 0.
- Memory mux: mem_en = if_gnt | d_gnt.
  - On d_gnt: mem_we = d_we; mem_addr/mem_wdata come from the data port.
  - On if_gnt: mem_we = 0; mem_addr comes from if_addr.
  - When idle: mem_we = 0 and mem_addr/mem_wdata are 0.
- Response tracking uses the registered read owner rd_own, with states NONE, IF, D.
  - If rd_own is IF at cycle N+1, then if_rvalid=1 and if_rdata=mem_rdata.
  - If rd_own is D, the same applies on the data side.
  - Stores set rd_own to NONE, so they produce no d_rvalid.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Back-to-back grants are allowed every cycle. A new grant in cycle N+1 does not disturb the response for the grant in cycle N.
- Requester protocol violations are not checked: dropping a request before it is granted, or changing its address while waiting.

## Timing
- Reset, while RST=1 or in the first cycle after it:
  - if_gnt, d_gnt, mem_en and mem_we are 0; grants are masked while RST=1.
  - rd_own is NONE, if_rvalid and d_rvalid are 0, starve_cnt is 0.
- Reset mid-operation: a read granted in the cycle RST rises produces no rvalid.
- Grant latency: 0 cycles from req to gnt when uncontested. Worst case for fetch is STARVE_MAX+1 cycles from if_req to if_gnt under continuous data requests.
- Read latency: rvalid rises exactly one cycle after the gnt cycle.
- Throughput: one access per cycle. Total rvalid pulses equal the number of granted reads.

## Configuration
- ARB_STATS_EN defined:
  - Adds output conflict_cnt [15:0], which counts cycles where if_req and d_req are both 1 and saturates at 16'hFFFF.
  - Adds output starve_evt [7:0], which counts forced fetch grants and saturates at 8'hFF.
  - Both counters clear on RST.
- ARB_STATS_EN undefined: the ports and registers are absent, and arbitration behaviour is identical.

## Test plan
- Reset then idle:
  - Hold RST for 2 cycles; all outputs read 0.
  - Release RST, hold if_req=d_req=0 for 5 cycles; mem_en stays 0.
- Lone fetch:
  - Preload RAM[0x004]=0xDEADBEEF, pulse if_req with if_addr=0x004.
  - Expect if_gnt in the same cycle, then if_rvalid=1 and if_rdata=0xDEADBEEF one cycle later.
- Store then load:
  - Issue d_req with d_we=1, d_addr=0x010, d_wdata=0x12345678 and observe no d_rvalid.
  - Next cycle issue a load from 0x010; expect d_rvalid with 0x12345678 one cycle after its grant.
- Starvation bound:
  - Hold if_req and d_req high continuously with STARVE_MAX=3.
  - Expect the grant pattern D, D, D, IF, repeating.
  - The fetch is first granted on cycle 4.
- Interleaved responses:
  - Grant a fetch at cycle N and a load at N+1.
  - Expect if_rvalid only at N+1 and d_rvalid only at N+2, each carrying the correct word.
- Reset mid-read:
  - Grant a load, then assert RST the next cycle.
  - Expect d_rvalid=0 and, with ARB_STATS_EN, conflict_cnt=0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the fetch port and the load/store port; data wins
// until fetch has been denied STARVE_MAX times in a row. ARB_STATS_EN adds event counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [7:0]        starve_evt
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } own_e;

  own_e       r_rd_own;
  own_e       w_rd_own_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       w_if_gnt;
  logic       w_d_gnt;
  logic       w_starved;

  // Grant decision; everything is masked while reset is held.
  always_comb begin
    w_starved = (r_starve_cnt == StarveMax);
    w_if_gnt  = !RST && if_req && (!d_req || w_starved);
    w_d_gnt   = !RST && d_req && !w_if_gnt;
  end

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_if_gnt || !if_req) begin
      w_starve_nxt = 4'd0;
    end else if (w_d_gnt && !w_starved) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve_cnt <= 4'd0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    mem_en    = w_if_gnt || w_d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Read-owner FSM: state register, next state, outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_own <= OwnNone;
    end else begin
      r_rd_own <= w_rd_own_nxt;
    end
  end

  always_comb begin
    w_rd_own_nxt = OwnNone;
    if (w_if_gnt) begin
      w_rd_own_nxt = OwnIf;
    end else if (w_d_gnt && !d_we) begin
      w_rd_own_nxt = OwnD;
    end
  end

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (!RST) begin
      unique case (r_rd_own)
        OwnIf: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        OwnD: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [7:0]  r_starve_evt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_conflict_cnt <= 16'd0;
      r_starve_evt   <= 8'd0;
    end else begin
      if (if_req && d_req && (r_conflict_cnt != 16'hFFFF)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
      if (w_if_gnt && d_req && (r_starve_evt != 8'hFF)) begin
        r_starve_evt <= r_starve_evt + 8'd1;
      end
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign starve_evt   = r_starve_evt;
`endif

endmodule
